// File: rtl/lcd_write_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : lcd_write_arbiter_if
// Description : Bundle of requester-side and byte-writer-side signals around
//               the LCD write arbiter.
//               master : environment side (requesters + byte-writer) drives
//                        req/doWrite/data/rs and writeByteReady/writeByteDone.
//               slave  : arbiter side, drives grant/readyOut/doneOut and the
//                        byte-writer command (dataOut/rsOut/doWriteByte).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lcd_write_arbiter_if;
  // requester side
  logic [2:0] req;
  logic [2:0] doWrite;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] rs;
  logic [2:0] grant;
  logic [2:0] readyOut;
  logic [2:0] doneOut;
  // byte-writer side
  logic       writeByteReady;
  logic       writeByteDone;
  logic [7:0] dataOut;
  logic       rsOut;
  logic       doWriteByte;

  modport master (
    output req, doWrite, data0, data1, data2, rs,
    output writeByteReady, writeByteDone,
    input  grant, readyOut, doneOut, dataOut, rsOut, doWriteByte
  );

  modport slave (
    input  req, doWrite, data0, data1, data2, rs,
    input  writeByteReady, writeByteDone,
    output grant, readyOut, doneOut, dataOut, rsOut, doWriteByte
  );
endinterface

`default_nettype wire

// File: rtl/lcd_write_arbiter.sv
//------------------------------------------------------------------------------
// Module      : lcd_write_arbiter
// Description : Shares one LCD byte-writer between three requesters
//               (0 = config sequencer, 1 = character writer, 2 = cursor/cmd).
//               A requester locks the writer for a whole transaction; only the
//               owner's data/rs/doWrite reach the byte-writer and only the
//               owner sees ready/done.
// Ports       : CLK, RESET (async, active-high)
//               bus (slave modport):
//                 req/doWrite/data0..2/rs      in  from requesters
//                 writeByteReady/writeByteDone in  from byte-writer
//                 grant/readyOut/doneOut       out to requesters
//                 dataOut/rsOut/doWriteByte    out to byte-writer
// Options     : LCD_ARB_RR_EN - round-robin arbitration when defined,
//               fixed priority 0 > 1 > 2 otherwise.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_write_arbiter (
  input wire logic           CLK,
  input wire logic           RESET,
  lcd_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_WRITING = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] own_q,   own_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] data_q,  data_d;
  logic       rs_q,    rs_d;

  // owner-selected view of the requester inputs
  logic       w_own_req;
  logic       w_own_dowrite;
  logic [7:0] w_own_data;
  logic       w_own_rs;
  logic [2:0] w_own_onehot;
  logic [1:0] w_winner;

  always_comb begin
    w_own_req     = bus.req[0];
    w_own_dowrite = bus.doWrite[0];
    w_own_data    = bus.data0;
    w_own_rs      = bus.rs[0];
    w_own_onehot  = 3'b001;
    case (own_q)
      2'd1: begin
        w_own_req     = bus.req[1];
        w_own_dowrite = bus.doWrite[1];
        w_own_data    = bus.data1;
        w_own_rs      = bus.rs[1];
        w_own_onehot  = 3'b010;
      end
      2'd2: begin
        w_own_req     = bus.req[2];
        w_own_dowrite = bus.doWrite[2];
        w_own_data    = bus.data2;
        w_own_rs      = bus.rs[2];
        w_own_onehot  = 3'b100;
      end
      default: ;
    endcase
  end

`ifdef LCD_ARB_RR_EN
  // first requester at or after ptr, searching cyclically over 0..2
  always_comb begin
    logic found;
    int   j;
    w_winner = 2'd0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < 3; k++) begin
      j = (int'(ptr_q) + k) % 3;
      if (!found && bus.req[j]) begin
        w_winner = j[1:0];
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_winner = 2'd2;
    if (bus.req[0]) begin
      w_winner = 2'd0;
    end else if (bus.req[1]) begin
      w_winner = 2'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    rs_d    = rs_q;
    case (state_q)
      ST_IDLE: begin
        if ((|bus.req) && bus.writeByteReady) begin
          own_d   = w_winner;
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        // a pending write wins over a dropped req in the same cycle
        if (w_own_dowrite) begin
          data_d  = w_own_data;
          rs_d    = w_own_rs;
          state_d = ST_WRITING;
        end else if (!w_own_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_WRITING: begin
        // req is only re-evaluated once the byte completes, so no truncation
        if (bus.writeByteDone) begin
          state_d = w_own_req ? ST_OWNED : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
`ifdef LCD_ARB_RR_EN
        ptr_d = (own_q == 2'd2) ? 2'd0 : own_q + 2'd1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // grant is registered: derive it from the next state/owner
  always_comb begin
    grant_d = 3'b000;
    if (state_d == ST_OWNED || state_d == ST_WRITING) begin
      grant_d = 3'b001 << own_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      own_q   <= 2'd0;
      ptr_q   <= 2'd0;
      grant_q <= 3'b000;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
    end
  end

  logic w_owned;
  logic w_writing;
  assign w_owned   = (state_q == ST_OWNED) || (state_q == ST_WRITING);
  assign w_writing = (state_q == ST_WRITING);

  assign bus.grant       = grant_q;
  assign bus.readyOut    = w_owned   ? (w_own_onehot & {3{bus.writeByteReady}}) : 3'b000;
  assign bus.doneOut     = w_writing ? (w_own_onehot & {3{bus.writeByteDone}})  : 3'b000;
  assign bus.dataOut     = data_q;
  assign bus.rsOut       = rs_q;
  assign bus.doWriteByte = w_writing;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_lcd_write_arbiter
// Description : Directed self-checking bench for lcd_write_arbiter with a
//               simple byte-writer model (done pulse two cycles after strobe).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_write_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_pass   = 0;

  lcd_write_arbiter_if bus ();

  lcd_write_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // byte-writer model: accepts a strobe, waits, pulses done for one cycle
  logic       bw_busy = 1'b0;
  int         bw_cnt  = 0;
  logic [8:0] bytes_q[$];
  int         done_cnt[3];
  logic       ff_seen       = 1'b0;
  logic       nonowner_seen = 1'b0;

  always @(negedge CLK) begin
    if (RESET) begin
      bw_busy = 1'b0;
      bw_cnt  = 0;
      bus.writeByteDone = 1'b0;
    end else if (bus.writeByteDone) begin
      bus.writeByteDone = 1'b0;
    end else if (bw_busy) begin
      if (bw_cnt == 0) begin
        bus.writeByteDone = 1'b1;
        bw_busy = 1'b0;
      end else begin
        bw_cnt--;
      end
    end else if (bus.doWriteByte) begin
      bw_busy = 1'b1;
      bw_cnt  = 1;
      bytes_q.push_back({bus.rsOut, bus.dataOut});
    end
    bus.writeByteReady = ~bw_busy;
  end

  always @(negedge CLK) begin
    #2;
    for (int i = 0; i < 3; i++) if (bus.doneOut[i]) done_cnt[i]++;
    if (bus.dataOut == 8'hFF) ff_seen = 1'b1;
    if (bus.readyOut[2] || bus.doneOut[2]) nonowner_seen = 1'b1;
  end

  task automatic wait_grant(output logic [2:0] g);
    g = 3'b000;
    for (int c = 0; c < 20 && g == 3'b000; c++) begin
      @(negedge CLK); #1;
      g = bus.grant;
    end
  endtask

  task automatic do_byte(input int i, input logic [7:0] d, input logic r);
    logic got;
    @(negedge CLK); #1;
    case (i)
      0: bus.data0 = d;
      1: bus.data1 = d;
      default: bus.data2 = d;
    endcase
    bus.rs[i] = r;
    bus.doWrite[i] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK); #1;
      if (bus.doneOut[i]) got = 1'b1;
    end
    bus.doWrite[i] = 1'b0;
    n_checks++;
    if (got !== 1'b1) $display("FAIL byte_done req%0d: done seen=%b required=1", i, got);
    else n_pass++;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    logic [2:0] g;
    logic       seen;
    RESET = 1'b1;
    idle_cycles(2);
    RESET = 1'b0;
    idle_cycles(1);
    n_checks++; if (bus.grant !== 3'b000) $display("FAIL reset_grant: got %b required 000", bus.grant); else n_pass++;
    n_checks++; if (bus.dataOut !== 8'h00) $display("FAIL reset_data: got %h required 00", bus.dataOut); else n_pass++;
    n_checks++; if ({bus.rsOut, bus.doWriteByte} !== 2'b00) $display("FAIL reset_rs_strobe: got %b required 00", {bus.rsOut, bus.doWriteByte}); else n_pass++;
    n_checks++; if ({bus.readyOut, bus.doneOut} !== 6'b0) $display("FAIL reset_ready_done: got %b required 000000", {bus.readyOut, bus.doneOut}); else n_pass++;

    // reset in the middle of a write
    bus.req[0] = 1'b1;
    wait_grant(g);
    bus.data0 = 8'h28; bus.rs[0] = 1'b0; bus.doWrite[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK); #1;
      seen = bus.doWriteByte;
    end
    n_checks++; if (bus.dataOut !== 8'h28 || seen !== 1'b1) $display("FAIL reset_pre_write: data %h strobe %b required 28 1", bus.dataOut, seen); else n_pass++;
    RESET = 1'b1;
    #1;
    n_checks++; if ({bus.grant, bus.doWriteByte} !== 4'b0000) $display("FAIL reset_async_drop: grant,strobe %b required 0000", {bus.grant, bus.doWriteByte}); else n_pass++;
    n_checks++; if ({bus.dataOut, bus.rsOut, bus.readyOut, bus.doneOut} !== 15'b0) $display("FAIL reset_async_outputs: %h required 0", {bus.dataOut, bus.rsOut, bus.readyOut, bus.doneOut}); else n_pass++;
    bus.req = 3'b000; bus.doWrite = 3'b000;
    idle_cycles(2);
    RESET = 1'b0;
    bytes_q.delete();
    @(negedge CLK); #1;
    bus.req[1] = 1'b1;
    @(negedge CLK); #1;
    n_checks++; if (bus.grant !== 3'b010) $display("FAIL reset_fresh_grant: got %b required 010", bus.grant); else n_pass++;
    bus.req[1] = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_single_sequence;
    logic [2:0] g;
    logic [7:0] seq [4];
    seq[0] = 8'h28; seq[1] = 8'h06; seq[2] = 8'h0c; seq[3] = 8'h01;
    bytes_q.delete();
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    bus.req[0] = 1'b1;
    wait_grant(g);
    n_checks++; if (g !== 3'b001) $display("FAIL seq_grant: got %b required 001", g); else n_pass++;
    for (int k = 0; k < 4; k++) do_byte(0, seq[k], 1'b0);
    bus.req[0] = 1'b0;
    idle_cycles(3);
    n_checks++; if (bytes_q.size() !== 4) $display("FAIL seq_count: got %0d required 4", bytes_q.size()); else n_pass++;
    for (int k = 0; k < 4 && k < bytes_q.size(); k++) begin
      n_checks++;
      if (bytes_q[k] !== {1'b0, seq[k]}) $display("FAIL seq_byte%0d: got %h required %h", k, bytes_q[k], {1'b0, seq[k]});
      else n_pass++;
    end
    n_checks++; if (done_cnt[0] !== 4) $display("FAIL seq_done0: got %0d required 4", done_cnt[0]); else n_pass++;
    n_checks++; if (done_cnt[1] + done_cnt[2] !== 0) $display("FAIL seq_done_others: got %0d required 0", done_cnt[1] + done_cnt[2]); else n_pass++;
  endtask

  task automatic test_lock_hold;
    logic [2:0] g;
    int         bad;
    logic       got;
    bus.req[0] = 1'b1;
    wait_grant(g);
    bus.data0 = 8'h33; bus.rs[0] = 1'b1; bus.doWrite[0] = 1'b1;
    bus.req[1] = 1'b1;
    bad = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK); #1;
      if (bus.doneOut[0]) got = 1'b1;
      if (bus.grant !== 3'b001 || bus.readyOut[1] !== 1'b0) bad++;
    end
    bus.doWrite[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); #1;
      if (bus.grant !== 3'b001) bad++;
    end
    n_checks++; if (bad !== 0 || got !== 1'b1) $display("FAIL lock_hold: bad cycles %0d done %b required 0 1", bad, got); else n_pass++;
    bus.req[0] = 1'b0;
    @(negedge CLK); #1;
    n_checks++; if (bus.grant !== 3'b000) $display("FAIL lock_release1: got %b required 000", bus.grant); else n_pass++;
    @(negedge CLK); #1;
    n_checks++; if (bus.grant !== 3'b000) $display("FAIL lock_release2: got %b required 000", bus.grant); else n_pass++;
    @(negedge CLK); #1;
    n_checks++; if (bus.grant !== 3'b010) $display("FAIL lock_handover: got %b required 010", bus.grant); else n_pass++;
    bus.req[1] = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_simultaneous;
    logic [2:0] g;
    logic [2:0] exp_g [4];
    int         idx;
`ifdef LCD_ARB_RR_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
    RESET = 1'b1;
    idle_cycles(1);
    RESET = 1'b0;
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      n_checks++;
      if (g !== exp_g[k]) $display("FAIL simul_order%0d: got %b required %b", k, g, exp_g[k]);
      else n_pass++;
      idx = g[2] ? 2 : (g[1] ? 1 : 0);
      do_byte(idx, 8'h40 + 8'(k), 1'b1);
      bus.req[idx] = 1'b0;
      @(negedge CLK); #1;
      bus.req[idx] = 1'b1;
    end
    bus.req = 3'b000;
    idle_cycles(4);
  endtask

  task automatic test_late_release;
    logic [2:0] g;
    logic       seen;
    logic       got;
    int         bad;
    bytes_q.delete();
    bus.req[2] = 1'b1;
    wait_grant(g);
    n_checks++; if (g !== 3'b100) $display("FAIL late_grant: got %b required 100", g); else n_pass++;
    bus.data2 = 8'h5A; bus.rs[2] = 1'b1; bus.doWrite[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK); #1;
      seen = bus.doWriteByte;
    end
    n_checks++; if ({seen, bus.rsOut, bus.dataOut} !== {2'b11, 8'h5A}) $display("FAIL late_latch: got %b %b %h required 1 1 5a", seen, bus.rsOut, bus.dataOut); else n_pass++;
    bus.req[2] = 1'b0;
    bad = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge CLK); #1;
      if (bus.doneOut[2]) got = 1'b1;
      if (bus.doWriteByte !== 1'b1 || bus.dataOut !== 8'h5A) bad++;
    end
    bus.doWrite[2] = 1'b0;
    n_checks++; if (bad !== 0 || got !== 1'b1) $display("FAIL late_hold: bad cycles %0d done %b required 0 1", bad, got); else n_pass++;
    @(negedge CLK); #1;
    n_checks++; if ({bus.grant, bus.doWriteByte} !== 4'b0000) $display("FAIL late_release: grant,strobe %b required 0000", {bus.grant, bus.doWriteByte}); else n_pass++;
    idle_cycles(2);
    n_checks++; if (bytes_q.size() !== 1 || bytes_q[0] !== {1'b1, 8'h5A}) $display("FAIL late_byte: got %0d bytes first %h required 1 15a", bytes_q.size(), bytes_q.size() > 0 ? bytes_q[0] : 9'h0); else n_pass++;
  endtask

  task automatic test_ignore_nonowner;
    logic [2:0] g;
    bytes_q.delete();
    bus.req[0] = 1'b1;
    wait_grant(g);
    ff_seen = 1'b0; nonowner_seen = 1'b0;
    bus.data2 = 8'hFF; bus.rs[2] = 1'b1; bus.doWrite[2] = 1'b1;
    @(negedge CLK); #1;
    n_checks++; if (bus.readyOut !== 3'b001) $display("FAIL ign_ready_owner: got %b required 001", bus.readyOut); else n_pass++;
    do_byte(0, 8'h11, 1'b0);
    do_byte(0, 8'h22, 1'b1);
    bus.req[0] = 1'b0;
    idle_cycles(3);
    bus.doWrite[2] = 1'b0;
    n_checks++; if (ff_seen !== 1'b0) $display("FAIL ign_data: dataOut showed ff=%b required 0", ff_seen); else n_pass++;
    n_checks++; if (nonowner_seen !== 1'b0) $display("FAIL ign_ready_done2: seen=%b required 0", nonowner_seen); else n_pass++;
    n_checks++;
    if (bytes_q.size() !== 2 || bytes_q[0] !== {1'b0, 8'h11} || bytes_q[1] !== {1'b1, 8'h22})
      $display("FAIL ign_bytes: got %0d bytes required 2 (011,122)", bytes_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    bus.req = 3'b000; bus.doWrite = 3'b000; bus.rs = 3'b000;
    bus.data0 = 8'h00; bus.data1 = 8'h00; bus.data2 = 8'h00;
    bus.writeByteReady = 1'b1; bus.writeByteDone = 1'b0;
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    test_reset();
    test_single_sequence();
    test_lock_hold();
    test_simultaneous();
    test_late_release();
    test_ignore_nonowner();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
